pe_credit_node: RTL and testbench

Parametrised processing element for the NoC mesh: injects sequence-numbered flits into its router port under credit-based flow control and sinks flits ejected from the router into a local receive FIFO, returning one credit per consumed flit. Generalises the fixed 20-bit, 4-credit PE with configurable width, credit depth and injection rate. Adds correct handling of simultaneous send and credit return, plus traffic and error counters.

---
 rtl/pe_pkg.sv | 27 ++
 rtl/pe_rx_fifo.sv | 43 ++++
 rtl/pe_credit_node.sv | 150 +++++++++++++++
 tb/tb_pe_credit_node.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the pe_credit_node slice.
// PE_SEQ_CHECK_EN adds the sequence-check error bit, widening err to 3 bits.
package pe_pkg;

  localparam int unsigned DefDataW = 20;
  localparam int unsigned DefNodeW = 4;
  localparam int unsigned DefSeqW  = DefDataW - 2 * DefNodeW;

  typedef struct packed {
    logic [DefNodeW-1:0] dest;
    logic [DefNodeW-1:0] src;
    logic [DefSeqW-1:0]  seq;
  } flit_t;

  localparam int unsigned ErrRxOvf   = 0;
  localparam int unsigned ErrCredOvf = 1;
  localparam int unsigned ErrSeq     = 2;

`ifdef PE_SEQ_CHECK_EN
  localparam int unsigned ErrW = 3;
`else
  localparam int unsigned ErrW = 2;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StSend} inj_state_e;

endpackage

// File: rtl/pe_rx_fifo.sv
// Parametrised synchronous FIFO for the PE receive path; Depth must be a power of two.
module pe_rx_fifo #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   cnt_q;

  assign full_o  = (cnt_q == (AddrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pe_credit_node.sv
// NoC processing element: credit-controlled flit injection plus a local RX FIFO sink.
// Define PE_SEQ_CHECK_EN to add per-source sequence checking (err widens to 3 bits).
module pe_credit_node
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NODE_W   = DefNodeW,
  parameter int unsigned NODE_ID  = 0,
  parameter int unsigned CREDITS  = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              inj_en,
  input  logic [7:0]        inj_gap,
  input  logic [NODE_W-1:0] dest_id,
  output logic [DATA_W-1:0] dataout,
  output logic              out_valid,
  input  logic              ci,
  input  logic [DATA_W-1:0] datain,
  input  logic              in_valid,
  input  logic              sink_ready,
  output logic              co,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count,
  output logic [ErrW-1:0]   err
);

  localparam int unsigned SeqW    = DATA_W - 2 * NODE_W;
  localparam logic [3:0]  CredMax = 4'(CREDITS);

  logic [3:0]      cred_q, cred_d;
  logic [7:0]      gap_q, gap_d;
  logic [SeqW-1:0] seq_q;
  logic            send, cred_ovf;
  inj_state_e      state_q;

  assign send = inj_en && (cred_q != '0) && (gap_q >= inj_gap);

  // A send and a returned credit in the same cycle cancel out.
  always_comb begin
    cred_d   = cred_q;
    cred_ovf = 1'b0;
    if (send && !ci) begin
      cred_d = cred_q - 4'd1;
    end else if (ci && !send) begin
      if (cred_q == CredMax) cred_ovf = 1'b1;
      else                   cred_d   = cred_q + 4'd1;
    end
    gap_d = send ? 8'd0 : ((gap_q == 8'hff) ? gap_q : gap_q + 8'd1);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cred_q <= CredMax;
      gap_q  <= 8'hff;
    end else begin
      cred_q <= cred_d;
      gap_q  <= gap_d;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      dataout  <= '0;
      seq_q    <= '0;
      tx_count <= '0;
    end else begin
      if (!inj_en)   state_q <= StIdle;
      else if (send) state_q <= StSend;
      else           state_q <= StWait;
      if (send) begin
        dataout  <= {dest_id, NODE_W'(NODE_ID), seq_q};
        seq_q    <= seq_q + 1'b1;
        tx_count <= tx_count + 16'd1;
      end
    end
  end

  assign out_valid = (state_q == StSend);

  logic              rx_full, rx_empty, push, pop, rx_ovf;
  logic [DATA_W-1:0] rx_data;
  logic [ErrW-1:0]   err_d;

  assign pop    = sink_ready && !rx_empty;
  assign push   = in_valid && (!rx_full || pop);
  assign rx_ovf = in_valid && rx_full && !pop;

  pe_rx_fifo #(
    .Width (DATA_W),
    .Depth (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (RST),
    .push_i  (push),
    .wdata_i (datain),
    .pop_i   (pop),
    .rdata_o (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

`ifdef PE_SEQ_CHECK_EN
  logic [SeqW-1:0]   exp_seq_q [2**NODE_W];
  logic [NODE_W-1:0] rx_src;
  logic [SeqW-1:0]   rx_seq;
  logic              seq_err;
  logic              unused_rx;

  assign rx_src    = rx_data[SeqW +: NODE_W];
  assign rx_seq    = rx_data[SeqW-1:0];
  assign seq_err   = pop && (rx_seq != exp_seq_q[rx_src]);
  assign unused_rx = ^rx_data[DATA_W-1 -: NODE_W];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2**NODE_W; i++) exp_seq_q[i] <= '0;
    end else if (pop) begin
      exp_seq_q[rx_src] <= rx_seq + 1'b1;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^rx_data;
`endif

  always_comb begin
    err_d = err;
    if (rx_ovf)   err_d[ErrRxOvf]   = 1'b1;
    if (cred_ovf) err_d[ErrCredOvf] = 1'b1;
`ifdef PE_SEQ_CHECK_EN
    if (seq_err)  err_d[ErrSeq]     = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      co       <= 1'b0;
      rx_count <= '0;
      err      <= '0;
    end else begin
      co  <= pop;
      err <= err_d;
      if (pop) rx_count <= rx_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pe_credit_node.sv
// Randomised bench for pe_credit_node against a queue/integer reference model,
// plus directed scenarios pinned with hand-computed literals.
module tb_pe_credit_node;
  import pe_pkg::*;

  localparam int unsigned DATA_W   = 20;
  localparam int unsigned NODE_W   = 4;
  localparam int unsigned NODE_ID  = 5;
  localparam int unsigned CREDITS  = 4;
  localparam int unsigned RX_DEPTH = 4;
  localparam int unsigned SeqW     = DATA_W - 2 * NODE_W;

  logic              clk = 1'b0;
  logic              RST = 1'b0;
  logic              inj_en = 1'b0;
  logic [7:0]        inj_gap = '0;
  logic [NODE_W-1:0] dest_id = '0;
  logic              ci = 1'b0;
  logic [DATA_W-1:0] datain = '0;
  logic              in_valid = 1'b0;
  logic              sink_ready = 1'b0;
  logic [DATA_W-1:0] dataout;
  logic              out_valid, co;
  logic [15:0]       tx_count, rx_count;
  logic [ErrW-1:0]   err;

  always #5 clk = ~clk;

  pe_credit_node #(
    .DATA_W   (DATA_W),
    .NODE_W   (NODE_W),
    .NODE_ID  (NODE_ID),
    .CREDITS  (CREDITS),
    .RX_DEPTH (RX_DEPTH)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .inj_en     (inj_en),
    .inj_gap    (inj_gap),
    .dest_id    (dest_id),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .ci         (ci),
    .datain     (datain),
    .in_valid   (in_valid),
    .sink_ready (sink_ready),
    .co         (co),
    .tx_count   (tx_count),
    .rx_count   (rx_count),
    .err        (err)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Reference model state
  int                m_cred, m_gap, m_seq, m_txc, m_rxc;
  bit                m_ov, m_co;
  logic [DATA_W-1:0] m_do;
  logic [ErrW-1:0]   m_err;
  logic [DATA_W-1:0] m_q[$];
  int                m_tbl[2**NODE_W];

  logic [DATA_W-1:0] ov_log[$];
  int                ov_cyc[$];
  int                co_pulses = 0;
  int                cyc = 0;

  function automatic logic [DATA_W-1:0] mk(input int dst, input int src, input int seq);
    flit_t f;
    f.dest = NODE_W'(dst);
    f.src  = NODE_W'(src);
    f.seq  = SeqW'(seq);
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cred = CREDITS; m_gap = 255; m_seq = 0; m_txc = 0; m_rxc = 0;
    m_ov = 0; m_co = 0; m_do = '0; m_err = '0;
    m_q.delete();
    for (int i = 0; i < 2**NODE_W; i++) m_tbl[i] = 0;
  endtask

  task automatic model_step();
    bit send, pop;
    logic [DATA_W-1:0] f;
    send = inj_en && (m_cred != 0) && (m_gap >= int'(inj_gap));
    pop  = sink_ready && (m_q.size() != 0);
    if (send && !ci) m_cred = m_cred - 1;
    else if (ci && !send) begin
      if (m_cred == CREDITS) m_err[ErrCredOvf] = 1'b1;
      else m_cred = m_cred + 1;
    end
    m_gap = send ? 0 : ((m_gap == 255) ? 255 : m_gap + 1);
    m_ov = send;
    if (send) begin
      m_do  = mk(int'(dest_id), NODE_ID, m_seq);
      m_seq = (m_seq + 1) % (1 << SeqW);
      m_txc = (m_txc + 1) % 65536;
    end
    m_co = pop;
    if (pop) begin
      f = m_q.pop_front();
      m_rxc = (m_rxc + 1) % 65536;
`ifdef PE_SEQ_CHECK_EN
      if (int'(f[SeqW-1:0]) != m_tbl[f[SeqW +: NODE_W]]) m_err[ErrSeq] = 1'b1;
      m_tbl[f[SeqW +: NODE_W]] = (int'(f[SeqW-1:0]) + 1) % (1 << SeqW);
`else
      f = '0;
`endif
    end
    if (in_valid) begin
      if (m_q.size() < RX_DEPTH) m_q.push_back(datain);
      else m_err[ErrRxOvf] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("dataout", dataout, m_do);
    chk("co", co, m_co);
    chk("tx_count", tx_count, m_txc);
    chk("rx_count", rx_count, m_rxc);
    chk("err", err, m_err);
    if (out_valid === 1'b1) begin
      ov_log.push_back(dataout);
      ov_cyc.push_back(cyc);
    end
    if (co === 1'b1) co_pulses++;
    cyc++;
  endtask

  task automatic cycle(input bit ie, input int ig, input bit c, input int dst, input bit iv,
                       input logic [DATA_W-1:0] din, input bit sr);
    @(negedge clk);
    check_outputs();
    inj_en = ie; inj_gap = 8'(ig); ci = c; dest_id = NODE_W'(dst);
    in_valid = iv; datain = din; sink_ready = sr;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic clear_logs();
    ov_log.delete();
    ov_cyc.delete();
    co_pulses = 0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    RST = 1'b0;
    inj_en = 0; inj_gap = '0; ci = 0; dest_id = '0; in_valid = 0; datain = '0; sink_ready = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_co", co, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_err", err, 0);
    model_reset();
    @(negedge clk);
    RST = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Credit exhaustion
    clear_logs();
    repeat (8) cycle(1, 0, 0, 3, 0, '0, 0);
    chk("exh_pulses", ov_log.size(), 4);
    for (int i = 0; i < ov_log.size() && i < 4; i++) begin
      chk("exh_seq", ov_log[i][SeqW-1:0], i);
      if (i > 0) chk("exh_consecutive", ov_cyc[i] - ov_cyc[i-1], 1);
    end
    chk("exh_tx_count", tx_count, 4);

    // Simultaneous send and credit return holds cred at 1
    clear_logs();
    cycle(1, 0, 1, 3, 0, '0, 0);
    repeat (5) cycle(1, 0, 1, 3, 0, '0, 0);
    cycle(0, 0, 0, 3, 0, '0, 0);
    repeat (4) cycle(1, 0, 0, 3, 0, '0, 0);
    idle(2);
    chk("sim_pulses", ov_log.size(), 6);
    if (ov_cyc.size() >= 5) chk("sim_back_to_back", ov_cyc[4] - ov_cyc[0], 4);
    chk("sim_tx_count", tx_count, 10);

    // Gap spacing with credits returned continuously
    do_reset();
    clear_logs();
    repeat (16) cycle(1, 3, 1, 10, 0, '0, 0);
    idle(1);
    chk("gap_pulses", ov_log.size(), 4);
    if (ov_log.size() >= 4) begin
      chk("gap_space0", ov_cyc[1] - ov_cyc[0], 4);
      chk("gap_space2", ov_cyc[3] - ov_cyc[2], 4);
      chk("gap_flit0", ov_log[0], 32'hA5000);
      chk("gap_flit1", ov_log[1], 32'hA5001);
    end
    chk("gap_err", err, 2);

    // RX overflow
    do_reset();
    clear_logs();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, mk(0, 2, i), 0);
    idle(1);
    chk("rxovf_err", err, 1);
    chk("rxovf_rx_count", rx_count, 0);
    repeat (6) cycle(0, 0, 0, 0, 0, '0, 1);
    idle(2);
    chk("rxovf_co_pulses", co_pulses, 4);
    chk("rxovf_rx_count_after", rx_count, 4);

    // Credit overflow at reset level
    do_reset();
    clear_logs();
    cycle(0, 0, 1, 0, 0, '0, 0);
    idle(1);
    chk("crovf_err", err, 2);
    repeat (8) cycle(1, 0, 0, 1, 0, '0, 0);
    idle(2);
    chk("crovf_tx_count", tx_count, 4);
    chk("crovf_pulses", ov_log.size(), 4);

`ifdef PE_SEQ_CHECK_EN
    // Sequence gap 0,1,3 from source 2
    do_reset();
    cycle(0, 0, 0, 0, 1, mk(0, 2, 0), 1);
    cycle(0, 0, 0, 0, 1, mk(0, 2, 1), 1);
    cycle(0, 0, 0, 0, 1, mk(0, 2, 3), 1);
    cycle(0, 0, 0, 0, 0, '0, 1);
    chk("seq_err_before", err, 0);
    idle(1);
    chk("seq_err_after", err, 4);
`endif

    // Randomised traffic with one asynchronous reset mid-run
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      cycle(($urandom_range(3) != 0),
            (($urandom_range(7) == 0) ? int'($urandom_range(20)) : int'($urandom_range(3))),
            ($urandom_range(2) == 0),
            int'($urandom_range(15)),
            ($urandom_range(1) == 1),
            DATA_W'($urandom),
            ($urandom_range(2) != 0));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
